// File: rtl/spart_fifo_driver_if.sv
// SPART bus handshake bundle: chip select, direction, address and the
// receive/transmit status lines. The 8-bit data bus is tri-stated and stays
// a plain inout port on the driver.
interface spart_fifo_driver_if;
  logic       iocs;
  logic       iorw;
  logic [1:0] ioaddr;
  logic       rda;
  logic       tbr;

  modport master (output iocs, iorw, ioaddr, input rda, tbr);
  modport slave  (input iocs, iorw, ioaddr, output rda, tbr);
endinterface

// File: rtl/spart_fifo_driver.sv
// Host-side SPART driver: programs the baud divisor, drains received bytes
// into an echo FIFO (optionally upper-casing or discarding them) and writes
// them back to the transmitter, alternating RX/TX service when both are ready.
module spart_fifo_driver #(
  parameter int CLK_FREQ   = 50_000_000,
  parameter int FIFO_DEPTH = 8,
  parameter int DIV_W      = 16
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic [1:0]                            br_cfg,
  input  logic [1:0]                            mode,
  spart_fifo_driver_if.master                   bus,
  inout  wire  [7:0]                            databus,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]       fifo_count,
  output logic                                  fifo_full
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

  localparam logic [DIV_W-1:0] DIV_4800  = DIV_W'(CLK_FREQ / (16 * 4800)  - 1);
  localparam logic [DIV_W-1:0] DIV_9600  = DIV_W'(CLK_FREQ / (16 * 9600)  - 1);
  localparam logic [DIV_W-1:0] DIV_19200 = DIV_W'(CLK_FREQ / (16 * 19200) - 1);
  localparam logic [DIV_W-1:0] DIV_38400 = DIV_W'(CLK_FREQ / (16 * 38400) - 1);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_BAUD_HI = 3'd1;
  localparam logic [2:0] S_BAUD_LO = 3'd2;
  localparam logic [2:0] S_READ    = 3'd3;
  localparam logic [2:0] S_WRITE   = 3'd4;
  localparam logic [2:0] S_WAIT    = 3'd5;

  logic [2:0]       state;
  logic [1:0]       cfg_q;
  logic             last_tx;
  logic [7:0]       mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [DIV_W-1:0] div_sel;
  logic [7:0]       rx_byte;
  logic [7:0]       dout;
  logic             drive;
  logic             empty;
  logic             rx_ok;
  logic             tx_ok;
  logic             push;
  logic             pop;

  assign empty     = (fifo_count == '0);
  assign fifo_full = (fifo_count == CNT_W'(FIFO_DEPTH));
  assign rx_ok     = bus.rda & ~fifo_full;
  assign tx_ok     = bus.tbr & ~empty;
  assign push      = (state == S_READ) && (mode != 2'b10);
  assign pop       = (state == S_WRITE);

  // Divisor for the currently latched baud selection
  always_comb begin
    div_sel = DIV_9600;
    case (cfg_q)
      2'b00:   div_sel = DIV_4800;
      2'b01:   div_sel = DIV_9600;
      2'b10:   div_sel = DIV_19200;
      default: div_sel = DIV_38400;
    endcase
  end

  // Received-byte transform: mode 01 folds ASCII lowercase to uppercase
  always_comb begin
    rx_byte = databus;
    if (mode == 2'b01 && databus >= 8'h61 && databus <= 8'h7A)
      rx_byte = databus - 8'h20;
  end

  // Bus outputs decoded from state; reset masks them so the bus is
  // released in the very cycle reset is asserted
  always_comb begin
    bus.iocs   = 1'b0;
    bus.iorw   = 1'b1;
    bus.ioaddr = 2'b00;
    drive      = 1'b0;
    dout       = '0;
    if (!rst) begin
      case (state)
        S_BAUD_HI: begin
          bus.iocs   = 1'b1;
          bus.iorw   = 1'b0;
          bus.ioaddr = 2'b11;
          drive      = 1'b1;
          dout       = 8'(div_sel >> 8);
        end
        S_BAUD_LO: begin
          bus.iocs   = 1'b1;
          bus.iorw   = 1'b0;
          bus.ioaddr = 2'b10;
          drive      = 1'b1;
          dout       = div_sel[7:0];
        end
        S_READ: begin
          bus.iocs   = 1'b1;
        end
        S_WRITE: begin
          bus.iocs   = 1'b1;
          bus.iorw   = 1'b0;
          drive      = 1'b1;
          dout       = mem[rd_ptr];
        end
        default: ;
      endcase
    end
  end

  assign databus = drive ? dout : 'z;

  // FIFO storage write; contents need no reset since fifo_count gates use
  always_ff @(posedge clk) begin
    if (!rst && push)
      mem[wr_ptr] <= rx_byte;
  end

  // Control FSM, baud latch, round-robin flag and FIFO pointers/count
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_BAUD_HI;
      cfg_q      <= br_cfg;
      last_tx    <= 1'b1;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (br_cfg != cfg_q) begin
            cfg_q <= br_cfg;
            state <= S_BAUD_HI;
          end else if (rx_ok && (!tx_ok || last_tx)) begin
            last_tx <= 1'b0;
            state   <= S_READ;
          end else if (tx_ok) begin
            last_tx <= 1'b1;
            state   <= S_WRITE;
          end
        end
        S_BAUD_HI: state <= S_BAUD_LO;
        S_BAUD_LO: state <= S_WAIT;
        S_READ: begin
          if (push) begin
            wr_ptr     <= wr_ptr + 1'b1;
            fifo_count <= fifo_count + 1'b1;
          end
          state <= S_WAIT;
        end
        S_WRITE: begin
          rd_ptr     <= rd_ptr + 1'b1;
          fifo_count <= fifo_count - 1'b1;
          state      <= S_WAIT;
        end
        S_WAIT:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spart_fifo_driver.sv
// Directed bench for spart_fifo_driver with a small SPART bus model.
module tb_spart_fifo_driver;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] br_cfg;
  logic [1:0] mode;
  wire  [7:0] databus;
  logic [3:0] fifo_count;
  logic       fifo_full;

  int n_vec;
  int n_bad;

  always #5 clk = ~clk;

  spart_fifo_driver_if bus_if ();

  spart_fifo_driver #(
    .CLK_FREQ  (50_000_000),
    .FIFO_DEPTH(8),
    .DIV_W     (16)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .br_cfg    (br_cfg),
    .mode      (mode),
    .bus       (bus_if),
    .databus   (databus),
    .fifo_count(fifo_count),
    .fifo_full (fifo_full)
  );

  // SPART model: manual rda/byte for single transfers, or an auto table
  logic        auto_rx;
  logic        rda_man;
  logic [7:0]  rx_man;
  logic        tbr;
  logic [7:0]  rx_tab [32];
  int unsigned rx_n;
  int unsigned rx_idx = 0;
  int unsigned cyc = 0;
  logic [7:0]  rx_cur;

  logic [7:0]  wr_q [$];
  bit          op_kind [$];
  int unsigned op_cyc [$];

  assign bus_if.rda = auto_rx ? (rx_idx < rx_n) : rda_man;
  assign bus_if.tbr = tbr;
  assign rx_cur     = auto_rx ? rx_tab[rx_idx[4:0]] : rx_man;
  assign databus    = (bus_if.iocs && bus_if.iorw) ? rx_cur : 'z;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (bus_if.iocs && bus_if.ioaddr == 2'b00) begin
      op_kind.push_back(!bus_if.iorw);
      op_cyc.push_back(cyc);
      if (bus_if.iorw) begin
        if (auto_rx) rx_idx <= rx_idx + 1;
      end else begin
        wr_q.push_back(databus);
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_bus(input string tag, input logic cs, input logic rw, input logic [1:0] addr);
    chk({tag, ".iocs"}, 32'(bus_if.iocs), 32'(cs));
    chk({tag, ".iorw"}, 32'(bus_if.iorw), 32'(rw));
    chk({tag, ".ioaddr"}, 32'(bus_if.ioaddr), 32'(addr));
  endtask

  task automatic chk_data(input string tag, input logic [7:0] exp);
    chk({tag, ".data"}, 32'(databus), 32'(exp));
  endtask

  task automatic wait_for(input string tag, input logic rw, input logic [1:0] addr, input int budget);
    bit hit;
    hit = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (bus_if.iocs && bus_if.iorw == rw && bus_if.ioaddr == addr) begin
        hit = 1'b1;
        break;
      end
      next_cycle();
    end
    chk({tag, ".seen"}, 32'(hit), 32'd1);
  endtask

  task automatic wait_count(input string tag, input logic [3:0] exp, input int budget);
    for (int i = 0; i < budget; i++) begin
      if (fifo_count == exp) break;
      next_cycle();
    end
    chk({tag, ".count"}, 32'(fifo_count), 32'(exp));
  endtask

  task automatic wait_ops(input int unsigned want, input int budget);
    for (int i = 0; i < budget; i++) begin
      if (op_kind.size() >= want) break;
      next_cycle();
    end
  endtask

  // One manual echo transfer starting from IDLE with tbr high
  task automatic do_echo(input string tag, input logic [1:0] m, input logic [7:0] b,
                         input bit wr, input logic [7:0] exp);
    mode    = m;
    rx_man  = b;
    rda_man = 1'b1;
    next_cycle();
    chk_bus({tag, ".rd"}, 1'b1, 1'b1, 2'b00);
    rda_man = 1'b0;
    next_cycle();
    next_cycle();
    next_cycle();
    if (wr) begin
      chk_bus({tag, ".wr"}, 1'b1, 1'b0, 2'b00);
      chk_data(tag, exp);
    end else begin
      chk({tag, ".nowr.iocs"}, 32'(bus_if.iocs), 32'd0);
      chk({tag, ".count"}, 32'(fifo_count), 32'd0);
    end
    next_cycle();
    next_cycle();
  endtask

  typedef struct {
    logic [1:0] m;
    logic [7:0] b;
    bit         wr;
    logic [7:0] exp;
  } echo_vec_t;

  echo_vec_t echo_tab [6] = '{
    '{2'b00, 8'h61, 1'b1, 8'h61},
    '{2'b01, 8'h61, 1'b1, 8'h41},
    '{2'b01, 8'h7A, 1'b1, 8'h5A},
    '{2'b01, 8'h7B, 1'b1, 8'h7B},
    '{2'b11, 8'h7A, 1'b1, 8'h7A},
    '{2'b10, 8'h61, 1'b0, 8'h00}
  };

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned base;
    int unsigned r0;
    logic [7:0]  got;

    n_vec   = 0;
    n_bad   = 0;
    rst     = 1'b1;
    br_cfg  = 2'b01;
    mode    = 2'b00;
    tbr     = 1'b0;
    rda_man = 1'b0;
    rx_man  = 8'h00;
    auto_rx = 1'b0;
    rx_n    = 0;
    for (int i = 0; i < 32; i++) rx_tab[i] = 8'(8'h30 + i);

    // T1: reset values, then divisor 9600 = 324 = 0x0144
    repeat (2) next_cycle();
    chk_bus("rst", 1'b0, 1'b1, 2'b00);
    chk("rst.count", 32'(fifo_count), 32'd0);
    chk("rst.full", 32'(fifo_full), 32'd0);
    rst = 1'b0;
    #1;
    chk_bus("t1.hi", 1'b1, 1'b0, 2'b11);
    chk_data("t1.hi", 8'h01);
    next_cycle();
    chk_bus("t1.lo", 1'b1, 1'b0, 2'b10);
    chk_data("t1.lo", 8'h44);
    next_cycle();
    chk("t1.wait.iocs", 32'(bus_if.iocs), 32'd0);
    next_cycle();
    chk_bus("t1.idle", 1'b0, 1'b1, 2'b00);

    // T2: reconfigure to 38400 = 80 = 0x0050
    br_cfg = 2'b11;
    next_cycle();
    chk_bus("t2.hi", 1'b1, 1'b0, 2'b11);
    chk_data("t2.hi", 8'h00);
    next_cycle();
    chk_bus("t2.lo", 1'b1, 1'b0, 2'b10);
    chk_data("t2.lo", 8'h50);
    next_cycle();
    next_cycle();
    chk("t2.count", 32'(fifo_count), 32'd0);

    // T3: single echo per mode with fixed READ->WRITE latency
    tbr = 1'b1;
    for (int i = 0; i < 6; i++)
      do_echo($sformatf("t3.%0d", i), echo_tab[i].m, echo_tab[i].b, echo_tab[i].wr, echo_tab[i].exp);

    // T4: 9 bytes with tbr low fill the FIFO, 9th stays pending
    tbr     = 1'b0;
    mode    = 2'b00;
    auto_rx = 1'b1;
    base    = wr_q.size();
    rx_n    = 9;
    repeat (40) next_cycle();
    chk("t4.count", 32'(fifo_count), 32'd8);
    chk("t4.full", 32'(fifo_full), 32'd1);
    chk("t4.reads", rx_idx, 32'd8);
    chk("t4.rda", 32'(bus_if.rda), 32'd1);
    tbr = 1'b1;
    for (int i = 0; i < 80; i++) begin
      if (wr_q.size() >= base + 9) break;
      next_cycle();
    end
    for (int i = 0; i < 9; i++) begin
      got = (wr_q.size() > base + i) ? wr_q[base + i] : 8'hEE;
      chk($sformatf("t4.wr%0d", i), 32'(got), 32'(8'h30 + i));
    end
    wait_count("t4.drain", 4'd0, 20);
    chk("t4.reads_all", rx_idx, 32'd9);

    // T5: preload two bytes, then RX and TX both ready alternate W,R,W,...
    tbr  = 1'b0;
    rx_n = 11;
    wait_count("t5.pre", 4'd2, 30);
    base = op_kind.size();
    r0   = wr_q.size();
    rx_n = 24;
    tbr  = 1'b1;
    wait_ops(base + 8, 60);
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("t5.kind%0d", i),
          (op_kind.size() > base + i) ? 32'(op_kind[base + i]) : 32'hEE,
          32'((i % 2) == 0));
      if (i > 0)
        chk($sformatf("t5.gap%0d", i),
            (op_cyc.size() > base + i) ? op_cyc[base + i] - op_cyc[base + i - 1] : 32'hEE,
            32'd3);
    end
    for (int i = 0; i < 4; i++) begin
      got = (wr_q.size() > r0 + i) ? wr_q[r0 + i] : 8'hEE;
      chk($sformatf("t5.wr%0d", i), 32'(got), 32'(8'h39 + i));
    end
    rx_n = rx_idx;
    wait_count("t5.drain", 4'd0, 60);

    // T6 setup: reconfig to 4800 = 650 = 0x028A while FIFO holds 3 bytes
    tbr  = 1'b0;
    rx_n = rx_idx + 3;
    wait_count("t6.load", 4'd3, 40);
    br_cfg = 2'b00;
    wait_for("t6.cfg", 1'b0, 2'b11, 6);
    chk_data("t6.cfg.hi", 8'h02);
    next_cycle();
    chk_bus("t6.cfg.lo", 1'b1, 1'b0, 2'b10);
    chk_data("t6.cfg.lo", 8'h8A);
    chk("t6.cfg.count", 32'(fifo_count), 32'd3);

    // T6: reset asserted in the middle of a WRITE
    tbr = 1'b1;
    wait_for("t6.wr", 1'b0, 2'b00, 10);
    rst = 1'b1;
    #1;
    chk("t6.rel.iocs", 32'(bus_if.iocs), 32'd0);
    next_cycle();
    chk_bus("t6.rst", 1'b0, 1'b1, 2'b00);
    chk("t6.rst.count", 32'(fifo_count), 32'd0);
    chk("t6.rst.full", 32'(fifo_full), 32'd0);
    rx_n = rx_idx;
    rst  = 1'b0;
    #1;
    chk_bus("t6.hi", 1'b1, 1'b0, 2'b11);
    chk_data("t6.hi", 8'h02);
    next_cycle();
    chk_bus("t6.lo", 1'b1, 1'b0, 2'b10);
    chk_data("t6.lo", 8'h8A);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
